// File: rtl/johnson_decoder.sv
// Johnson code decoder: maps a WIDTH-bit Johnson word to a binary index and a
// one-hot vector, flags illegal words and broken sequences, and tracks lock.
module johnson_decoder #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int ERR_W    = 8,
    localparam int IDX_W    = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     code,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     index,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 illegal_code,
    output logic                 seq_error,
    output logic                 locked,
    output logic [ERR_W-1:0]     err_count
);

    localparam int N = 2 * WIDTH;
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   prev_r;
    logic [3:0]         cnt_r;

    logic               legal_s;
    logic [IDX_W-1:0]   idx_s;
    logic [IDX_W-1:0]   succ_s;
    logic               is_succ_s;
    logic               is_repeat_s;
    logic [N-1:0]       onehot_s;
    logic [ERR_W-1:0]   err_inc_s;

    // Legal word for state k: k ones filling from the MSB, then draining from the MSB.
    function automatic logic [WIDTH-1:0] johnson_word(input int k);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH) begin
                w[i] = (i >= WIDTH - k);
            end else begin
                w[i] = (i < N - k);
            end
        end
        return w;
    endfunction

    // Decode the sampled word and derive the continuity and error-count helpers.
    always_comb begin
        legal_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            legal_s = legal_s | (code == johnson_word(k));
            idx_s   = (code == johnson_word(k)) ? IDX_W'(k) : idx_s;
        end
        succ_s      = (prev_r == LAST_IDX) ? '0 : prev_r + IDX_W'(1);
        is_succ_s   = (idx_s == succ_s);
        is_repeat_s = (idx_s == prev_r);
        onehot_s    = {{(N-1){1'b0}}, 1'b1} << idx_s;
        err_inc_s   = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);
    end

    // Lock FSM together with every registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= HUNT;
            prev_r       <= '0;
            cnt_r        <= 4'd0;
            out_valid    <= 1'b0;
            index        <= '0;
            onehot       <= '0;
            illegal_code <= 1'b0;
            seq_error    <= 1'b0;
            locked       <= 1'b0;
            err_count    <= '0;
        end else begin
            out_valid    <= 1'b0;
            onehot       <= '0;
            illegal_code <= 1'b0;
            seq_error    <= 1'b0;
            if (in_valid && !legal_s) begin
                illegal_code <= 1'b1;
                err_count    <= err_inc_s;
                state_r      <= HUNT;
                locked       <= 1'b0;
                cnt_r        <= 4'd0;
            end else if (in_valid) begin
                out_valid <= 1'b1;
                index     <= idx_s;
                onehot    <= onehot_s;
                prev_r    <= idx_s;
                case (state_r)
                    HUNT: begin
                        cnt_r   <= 4'd0;
                        state_r <= CHECK;
                        locked  <= 1'b0;
                    end
                    CHECK: begin
                        if (is_succ_s) begin
                            cnt_r <= cnt_r + 4'd1;
                            if (cnt_r + 4'd1 == LOCK_TGT) begin
                                state_r <= LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                state_r <= CHECK;
                            end
                        end else if (is_repeat_s) begin
                            cnt_r <= cnt_r;
                        end else begin
                            // Jump to an unrelated legal word: start counting afresh, no error.
                            cnt_r <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (is_succ_s || is_repeat_s) begin
                            state_r <= LOCKED;
                        end else begin
                            seq_error <= 1'b1;
                            err_count <= err_inc_s;
                            cnt_r     <= 4'd0;
                            state_r   <= CHECK;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        cnt_r   <= 4'd0;
                        locked  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomised and directed bench for johnson_decoder against a behavioural
// model built from the code-map arithmetic and lock rules.
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int N  = 2 * W;
    localparam int LC = 3;
    localparam int EW = 8;
    localparam int IW = $clog2(N);
    localparam int OW = 1 + IW + N + 3 + EW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  code = '0;
    logic          out_valid;
    logic [IW-1:0] index;
    logic [N-1:0]  onehot;
    logic          illegal_code;
    logic          seq_error;
    logic          locked;
    logic [EW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 = hunting, 1 = checking, 2 = locked.
    int            m_phase, m_prev, m_cnt;
    logic          e_ov, e_ill, e_seq, e_lock;
    int            e_idx, e_err;
    logic [N-1:0]  e_oh;

    wire [OW-1:0] obs = {out_valid, index, onehot, illegal_code, seq_error, locked, err_count};

    johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
        .out_valid(out_valid), .index(index), .onehot(onehot),
        .illegal_code(illegal_code), .seq_error(seq_error),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] code_of(input int k);
        if (k <= W) return W'(((1 << k) - 1) << (W - k));
        else        return W'((1 << (N - k)) - 1);
    endfunction

    function automatic int index_of(input logic [W-1:0] c);
        for (int k = 0; k < N; k++) if (code_of(k) == c) return k;
        return -1;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {e_ov, IW'(e_idx), e_oh, e_ill, e_seq, e_lock, EW'(e_err)};
    endfunction

    task automatic m_reset();
        m_phase = 0; m_prev = 0; m_cnt = 0;
        e_ov = 0; e_ill = 0; e_seq = 0; e_lock = 0; e_idx = 0; e_err = 0; e_oh = '0;
    endtask

    task automatic m_step(input logic v, input logic [W-1:0] c);
        int k;
        e_ov = 0; e_oh = '0; e_ill = 0; e_seq = 0;
        if (!v) return;
        k = index_of(c);
        if (k < 0) begin
            e_ill = 1;
            if (e_err < (1 << EW) - 1) e_err++;
            m_phase = 0;
        end else begin
            e_ov = 1; e_idx = k; e_oh = N'(1) << k;
            if (m_phase == 0) begin
                m_phase = 1; m_cnt = 0;
            end else if (m_phase == 1) begin
                if (k == (m_prev + 1) % N) begin
                    m_cnt++;
                    if (m_cnt == LC) m_phase = 2;
                end else if (k != m_prev) m_cnt = 0;
            end else if (k != (m_prev + 1) % N && k != m_prev) begin
                e_seq = 1;
                if (e_err < (1 << EW) - 1) e_err++;
                m_cnt = 0; m_phase = 1;
            end
            m_prev = k;
        end
        e_lock = (m_phase == 2);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] c);
        @(negedge clk);
        in_valid = v; code = c;
        @(posedge clk);
        m_step(v, c);
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); code = W'($urandom);
            @(posedge clk); #1;
            checks++;
            if (obs !== '0) begin
                errors++; $display("FAIL reset_hold cyc %0d: got %h expected 0", i, obs);
            end
        end
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, W'($urandom));
            checks++;
            if (obs !== '0 || obs !== exp_vec()) begin
                errors++; $display("FAIL reset_idle cyc %0d: got %h expected 0", i, obs);
            end
        end
    endtask

    task automatic test_full_sequence();
        for (int i = 0; i <= N; i++) begin
            cycle(1'b1, code_of(i % N));
            checks++;
            if (obs !== exp_vec() || index !== IW'(i % N) || onehot !== N'(1) << (i % N)) begin
                errors++; $display("FAIL full_seq step %0d: got %h expected %h", i, obs, exp_vec());
            end
            checks++;
            if (locked !== (i >= LC) || seq_error !== 1'b0) begin
                errors++; $display("FAIL full_seq_lock step %0d: got locked=%b seq=%b expected locked=%b seq=0", i, locked, seq_error, i >= LC);
            end
        end
    endtask

    task automatic test_illegal();
        cycle(1'b1, 4'b1011);
        checks++;
        if (obs !== exp_vec() || illegal_code !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0 || locked !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse: got %h expected %h", obs, exp_vec());
        end
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, code_of(k));
            checks++;
            if (obs !== exp_vec() || locked !== (k == 4)) begin
                errors++; $display("FAIL illegal_relock k %0d: got %h expected %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_seq_error();
        int seq [9] = '{5, 6, 7, 0, 1, 2, 6, 7, 0};
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, code_of(seq[i]));
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL seq_err step %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 6) begin
                checks++;
                if (seq_error !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0) begin
                    errors++; $display("FAIL seq_err_pulse: got seq=%b err=%0d locked=%b expected 1 2 0", seq_error, err_count, locked);
                end
            end
        end
        cycle(1'b1, code_of(1));
        checks++;
        if (locked !== 1'b1 || seq_error !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL seq_err_relock: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_gaps_repeats();
        logic [W-1:0] words [8] = '{4'b1100, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b1111};
        logic         vals  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            cycle(vals[i], words[i]);
            checks++;
            if (obs !== exp_vec() || locked !== 1'b1 || illegal_code !== 1'b0 || seq_error !== 1'b0) begin
                errors++; $display("FAIL gaps step %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (!vals[i]) begin
                checks++;
                if (index !== 3'd2) begin
                    errors++; $display("FAIL gap_index_hold step %0d: got %0d expected 2", i, index);
                end
            end
        end
    endtask

    task automatic test_random();
        int cur = m_prev;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: cycle(1'b0, W'($urandom));
                1: cycle(1'b1, code_of(cur));
                2: begin cur = $urandom_range(0, N - 1); cycle(1'b1, code_of(cur)); end
                3: begin
                    cycle(1'b1, W'($urandom));
                    if (index_of(code) >= 0) cur = index_of(code);
                end
                default: begin cur = (cur + 1) % N; cycle(1'b1, code_of(cur)); end
            endcase
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random step %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 4'b0101);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL saturate step %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (err_count !== 8'hFF || illegal_code !== 1'b1) begin
            errors++; $display("FAIL saturate_final: got err=%0d ill=%b expected 255 1", err_count, illegal_code);
        end
        @(negedge clk);
        in_valid = 1'b1; code = 4'b0101;
        @(posedge clk);
        #3 reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs !== '0 || obs !== exp_vec()) begin
            errors++; $display("FAIL async_reset: got %h expected 0", obs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        cycle(1'b0, '0);
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL post_reset: got %h expected 0", obs);
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_illegal();
        test_seq_error();
        test_gaps_repeats();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
Receive-side companion to the team's Johnson counter. Samples a WIDTH-bit Johnson code word, decodes it to a binary index and a one-hot vector, checks code legality and sequence continuity, and runs a lock FSM that declares the incoming stream trustworthy. Sits downstream of any Johnson-coded counter or phase generator, including one crossing a clock boundary, where it acts as the decode and integrity-check stage.

Parameters:
WIDTH, 4, Johnson code width; the sequence has 2*WIDTH legal states.
LOCK_CNT, 3, consecutive correct successors required to enter LOCKED (range 1..15).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  input  1  code is sampled on this cycle.
code  input  WIDTH  Johnson code word.
out_valid  output  1  registered; index and onehot are meaningful.
index  output  IDX_W  decoded state number, where IDX_W = $clog2(2*WIDTH).
onehot  output  2*WIDTH  onehot[index] = 1 when out_valid is 1, otherwise all zero.
illegal_code  output  1  one-cycle pulse: the sampled word is not a legal Johnson code.
seq_error  output  1  one-cycle pulse: legal code, but not the expected successor while LOCKED.
locked  output  1  level; FSM is in LOCKED.
err_count  output  ERR_W  count of illegal_code plus seq_error events; saturates at all-ones.

Behaviour:
- Code map, index k:
  - k = 0..WIDTH: top k bits are 1, the rest 0.
  - k = WIDTH+1..2*WIDTH-1: bottom 2*WIDTH-k bits are 1, the rest 0.
  - WIDTH=4 sequence: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
  - Successor of k is (k+1) mod 2*WIDTH. This matches a counter that shifts right and loads ~LSB into the MSB.
  - All other words are illegal.
- Reset (reset=0, asynchronous):
  - out_valid=0, index=0, onehot=0, illegal_code=0, seq_error=0, locked=0, err_count=0.
  - FSM goes to HUNT; the held previous index is cleared to 0.
  - Reset asserted mid-stream discards lock immediately. Release is sampled on the next clk edge.
- Latency: every output is registered and reflects the in_valid sample from one cycle earlier.
- in_valid=0: out_valid=0, onehot=0, pulses=0. index, FSM state, prev index and counters all hold. Gaps are legal and do not break sequence continuity.
- Legal sample: out_valid=1, index=k, onehot=1<<k. prev index is updated to k.
- Illegal sample:
  - out_valid=0, onehot=0, illegal_code=1, err_count increments.
  - index and prev index hold.
  - FSM goes to HUNT from any state.
- FSM (in_valid samples only):
  - HUNT: on a legal code, capture prev=k, set match count=0, go to CHECK.
  - CHECK:
    - code == successor(prev): match count increments; when it reaches LOCK_CNT, go to LOCKED.
    - code == prev (a repeated sample): no change in state or count.
    - Any other legal code: restart CHECK with prev=k and match count=0. No error is flagged.
  - LOCKED:
    - Successor or repeat: stay in LOCKED.
    - Any other legal code: seq_error=1, err_count increments, prev=k, go to CHECK with match count=0.
    - locked drops on the same registered cycle as the seq_error pulse.
- Successor wrap: from index 2*WIDTH-1 (0001 for WIDTH=4), the expected successor is 0 (0000).
- err_count saturates at 2^ERR_W-1 and never wraps. illegal_code and seq_error are mutually exclusive by construction.
- locked goes to 1 on the cycle after the LOCK_CNT-th matching sample.

Test Plan:
1. Apply reset=0 for 3 cycles with random code, release, hold in_valid=0 → all outputs 0 and locked=0 for every cycle.
2. Drive the full sequence 0000,1000,…,0001,0000 with in_valid=1 each cycle → index 0..7,0 one cycle late; onehot=8'h01,8'h02,…,8'h80,8'h01; locked=1 from the cycle after the 4th sample (LOCK_CNT=3); wrap 0001→0000 gives no seq_error.
3. While LOCKED, inject 1011 → illegal_code pulse, err_count=1, out_valid=0, locked=0; resume the sequence → relock after 3 correct successors.
4. While LOCKED at index 2, drive 0011 (index 6) → seq_error=1, err_count increments, locked=0; then drive 0001,0000,1000 → locked=1 again.
5. Insert in_valid=0 gaps and repeated words (1100,1100) into the sequence → no errors, lock is held, index holds during the gaps.
6. Drive 300 illegal words (0101) → err_count saturates at 255. Assert reset=0 mid-stream, asynchronous to clk → outputs clear immediately, without waiting for a clock edge.
